// File: rtl/xrst_settlement_ingress.sv
// -----------------------------------------------------------------------------
// xrst_settlement_ingress
//
// Entry point of XRST for settlement records coming out of XRAS. Each record
// is taken over a valid/ready handshake. A record that repeats the previously
// stored settlement_id is consumed and dropped. Stored records get their type
// re-derived from the sign of the net value, feed running credit/penalty
// totals, are queued in a small FIFO and are then serialised as four 32-bit
// words (id, sla, net, corrected type) onto an outgoing stream.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   record handshake
//   in_settlement_id    upstream settlement identifier
//   in_sla_id           SLA identifier
//   in_net              net settlement, two's complement
//   in_type             upstream type (0 credit, 1 penalty, 2 adjustment)
//   out_valid/out_ready stream handshake
//   out_data, out_last  stream word and end-of-record marker
//   clear_stats         pulse that zeroes the totals and counters
//   total_credit        saturating sum of positive nets
//   total_penalty       saturating sum of magnitudes of negative nets
//   accepted_count      records written into the FIFO (wraps)
//   dup_count           duplicates dropped (saturating)
//   mismatch_count      records whose upstream type was corrected (saturating)
//   fifo_level          current FIFO occupancy
// -----------------------------------------------------------------------------
module xrst_settlement_ingress #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_settlement_id,
    input  logic [31:0]                   in_sla_id,
    input  logic [31:0]                   in_net,
    input  logic [7:0]                    in_type,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic                          out_last,
    input  logic                          clear_stats,
    output logic [31:0]                   total_credit,
    output logic [31:0]                   total_penalty,
    output logic [31:0]                   accepted_count,
    output logic [CNT_W-1:0]              dup_count,
    output logic [CNT_W-1:0]              mismatch_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] sla;
        logic [31:0] net;
        logic [1:0]  ctype;
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    rec_t          mem [FIFO_DEPTH];
    rec_t          shadow;
    rec_t          rec_in;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [31:0]   last_id;
    logic          have_last;
    logic          take;
    logic          dup;
    logic          push;
    logic          pop;
    logic [1:0]    corr_type;
    logic          type_mismatch;
    logic [32:0]   credit_sum;
    logic [31:0]   pen_mag;
    logic [32:0]   pen_sum;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          valid_q;
    logic          valid_nxt;

    // Ready is based purely on the registered level, so a pop in the same
    // cycle never opens a full FIFO.
    assign in_ready   = (level != FULL_LEVEL);
    assign fifo_level = level;

    assign take = in_valid & in_ready;
    assign dup  = have_last & (in_settlement_id == last_id);
    assign push = take & ~dup;

    // Type implied by the sign of the net value.
    always_comb begin
        corr_type = 2'd2;
        if ($signed(in_net) > 32'sd0) begin
            corr_type = 2'd0;
        end else if ($signed(in_net) < 32'sd0) begin
            corr_type = 2'd1;
        end
    end

    assign type_mismatch = (in_type != {6'd0, corr_type});
    assign rec_in        = '{id: in_settlement_id, sla: in_sla_id, net: in_net, ctype: corr_type};

    // Widened sums so the carry tells us when to saturate. Negating
    // 0x80000000 in 32 bits yields 0x80000000, which is exactly 2^31.
    assign credit_sum = {1'b0, total_credit} + {1'b0, in_net};
    assign pen_mag    = 32'd0 - in_net;
    assign pen_sum    = {1'b0, total_penalty} + {1'b0, pen_mag};

    // Record storage, left unreset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Duplicate filter remembers only the most recently stored id.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id   <= '0;
            have_last <= 1'b0;
        end else if (push) begin
            last_id   <= in_settlement_id;
            have_last <= 1'b1;
        end
    end

    // Totals and counters; clear_stats wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            total_credit   <= '0;
            total_penalty  <= '0;
            accepted_count <= '0;
            dup_count      <= '0;
            mismatch_count <= '0;
        end else begin
            if (take && dup && (dup_count != {CNT_W{1'b1}})) begin
                dup_count <= dup_count + CNT_W'(1);
            end
            if (push) begin
                accepted_count <= accepted_count + 32'd1;
                if (type_mismatch && (mismatch_count != {CNT_W{1'b1}})) begin
                    mismatch_count <= mismatch_count + CNT_W'(1);
                end
                if (corr_type == 2'd0) begin
                    total_credit <= credit_sum[32] ? 32'hFFFF_FFFF : credit_sum[31:0];
                end else if (corr_type == 2'd1) begin
                    total_penalty <= pen_sum[32] ? 32'hFFFF_FFFF : pen_sum[31:0];
                end
            end
        end
    end

    // Serialiser state register. The shadow takes the FIFO head on every pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            valid_q <= 1'b0;
            shadow  <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            valid_q <= valid_nxt;
            if (pop) begin
                shadow <= mem[rd_ptr];
            end
        end
    end

    // Serialiser next state. After a pop from IDLE the stream goes valid one
    // cycle later; on the final word the next record is popped straight into
    // the shadow so consecutive records flow without a gap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        valid_nxt = valid_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                    idx_nxt   = 2'd0;
                    valid_nxt = 1'b0;
                end
            end
            SEND: begin
                if (!valid_q) begin
                    valid_nxt = 1'b1;
                end else if (out_ready) begin
                    if (idx == 2'd3) begin
                        idx_nxt = 2'd0;
                        if (level != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            valid_nxt = 1'b0;
                        end
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
        endcase
    end

    assign out_valid = valid_q;
    assign out_last  = valid_q & (idx == 2'd3);

    // Word selection from the shadow record.
    always_comb begin
        out_data = '0;
        if (valid_q) begin
            case (idx)
                2'd0:    out_data = shadow.id;
                2'd1:    out_data = shadow.sla;
                2'd2:    out_data = shadow.net;
                default: out_data = {30'h0, shadow.ctype};
            endcase
        end
    end

endmodule
